cic_dec_iq: RTL and testbench

Multi-stage CIC decimator for I/Q baseband samples.
- Position: sits directly upstream of the 8x FIR decimator, between the mixer/NCO output and the FIR input.
- Rate change: reduces the ADC-rate I/Q stream by a fixed power-of-two factor R = 2^rsz. The DC gain is exactly unity, which leaves passband droop compensation and final decimation to the FIR.
- Hand-off: `valid`/`iout`/`qout` connect straight to the FIR's `ena`/`iin`/`qin`.

---
 rtl/cic_dec_iq_pkg.sv | 22 ++
 rtl/cic_rail.sv | 73 +++++++
 rtl/sat.sv | 23 ++
 rtl/cic_dec_iq.sv | 87 ++++++++
 tb/tb_cic_dec_iq.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_dec_iq_pkg.sv
// Shared configuration helpers for the I/Q CIC decimator: internal width,
// rounding-constant position and legal parameter ranges.
package cic_dec_iq_pkg;

  localparam int NSTG_MIN = 1;
  localparam int NSTG_MAX = 6;
  localparam int RSZ_MIN  = 1;

  function automatic int calc_asz(input int isz, input int nstg, input int rsz);
    return isz + nstg * rsz;
  endfunction

  // Bit position of the half-LSB added before dropping the R^nstg gain bits.
  function automatic int rnd_pos(input int nstg, input int rsz);
    return nstg * rsz - 1;
  endfunction

  function automatic bit cfg_ok(input int nstg, input int rsz);
    return (nstg >= NSTG_MIN) && (nstg <= NSTG_MAX) && (rsz >= RSZ_MIN);
  endfunction

endpackage

// File: rtl/cic_rail.sv
// One CIC rail: registered integrator chain, strobe-driven comb pipeline and
// round-half-up removal of the R^nstg gain (one extra bit kept for the carry).
module cic_rail
  import cic_dec_iq_pkg::*;
#(
  parameter int isz  = 16,
  parameter int nstg = 4,
  parameter int rsz  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ena,
  input  logic [nstg-1:0]        stb,
  input  logic signed [isz-1:0]  din,
  output logic [isz:0]           dout
);

  localparam int asz  = calc_asz(isz, nstg, rsz);
  localparam int rpos = rnd_pos(nstg, rsz);

  logic [asz-1:0] integ_q    [nstg];
  logic [asz-1:0] integ_d    [nstg];
  logic [asz-1:0] comb_x     [nstg];
  logic [asz-1:0] comb_y_q   [nstg];
  logic [asz-1:0] comb_y_d   [nstg];
  logic [asz-1:0] comb_dly_q [nstg];
  logic [asz-1:0] comb_dly_d [nstg];
  logic [asz:0]   rnd_sum;
  logic           unused_rnd;

  // Every integrator adds its predecessor's pre-update value; wrap is intended.
  always_comb begin
    for (int k = 0; k < nstg; k++) integ_d[k] = integ_q[k];
    if (ena) begin
      integ_d[0] = integ_q[0] + asz'(din);
      for (int k = 1; k < nstg; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  always_comb begin
    comb_x[0] = integ_q[nstg-1];
    for (int k = 1; k < nstg; k++) comb_x[k] = comb_y_q[k-1];
    for (int k = 0; k < nstg; k++) begin
      comb_y_d[k]   = comb_y_q[k];
      comb_dly_d[k] = comb_dly_q[k];
      if (stb[k]) begin
        comb_y_d[k]   = comb_x[k] - comb_dly_q[k];
        comb_dly_d[k] = comb_x[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < nstg; k++) begin
        integ_q[k]    <= '0;
        comb_y_q[k]   <= '0;
        comb_dly_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < nstg; k++) begin
        integ_q[k]    <= integ_d[k];
        comb_y_q[k]   <= comb_y_d[k];
        comb_dly_q[k] <= comb_dly_d[k];
      end
    end
  end

  assign rnd_sum    = {comb_y_q[nstg-1][asz-1], comb_y_q[nstg-1]} + ((asz+1)'(1) << rpos);
  assign dout       = rnd_sum[asz:rpos+1];
  assign unused_rnd = ^rnd_sum[rpos:0];

endmodule

// File: rtl/sat.sv
// Signed width reducer: clamps an iw-bit two's-complement value into ow bits,
// or sign-extends when the output is at least as wide.
module sat #(
  parameter int iw = 17,
  parameter int ow = 16
) (
  input  logic [iw-1:0] din,
  output logic [ow-1:0] dout
);

  if (ow >= iw) begin : g_ext
    assign dout = ow'($signed(din));
  end else begin : g_clip
    logic over;

    // Dropped bits must all equal the kept sign bit, otherwise clamp by sign.
    assign over = (din[iw-1:ow-1] != {(iw-ow+1){din[iw-1]}});
    assign dout = !over    ? din[ow-1:0] :
                  din[iw-1] ? {1'b1, {(ow-1){1'b0}}} :
                              {1'b0, {(ow-1){1'b1}}};
  end

endmodule

// File: rtl/cic_dec_iq.sv
// I/Q CIC decimator by R = 2^rsz with unity DC gain; shares one decimation
// counter and strobe pipe between the two rails.
module cic_dec_iq
  import cic_dec_iq_pkg::*;
#(
  parameter int isz  = 16,
  parameter int osz  = 16,
  parameter int nstg = 4,
  parameter int rsz  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic signed [isz-1:0] iin,
  input  logic signed [isz-1:0] qin,
  output logic                  valid,
  output logic signed [osz-1:0] iout,
  output logic signed [osz-1:0] qout
);

  if (!cfg_ok(nstg, rsz)) begin : g_cfg_err
    $error("cic_dec_iq: nstg must be in 1..6 and rsz must be >= 1");
  end

  logic [rsz-1:0] cnt_q, cnt_d;
  logic [nstg:0]  stb_q, stb_d;
  logic           valid_q, valid_d;
  logic [osz-1:0] iout_q, iout_d;
  logic [osz-1:0] qout_q, qout_d;
  logic [isz:0]   irnd, qrnd;
  logic [osz-1:0] isat, qsat;

  // stb_q[k] enables comb stage k; stb_q[nstg] loads the output registers.
  always_comb begin
    cnt_d = cnt_q;
    stb_d = {stb_q[nstg-1:0], 1'b0};
    if (ena) begin
      cnt_d    = cnt_q + rsz'(1);
      stb_d[0] = &cnt_q;
    end
    valid_d = stb_q[nstg];
    iout_d  = stb_q[nstg] ? isat : iout_q;
    qout_d  = stb_q[nstg] ? qsat : qout_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      stb_q   <= '0;
      valid_q <= 1'b0;
      iout_q  <= '0;
      qout_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      valid_q <= valid_d;
      iout_q  <= iout_d;
      qout_q  <= qout_d;
    end
  end

  cic_rail #(.isz(isz), .nstg(nstg), .rsz(rsz)) u_rail_i (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .stb   (stb_q[nstg-1:0]),
    .din   (iin),
    .dout  (irnd)
  );

  cic_rail #(.isz(isz), .nstg(nstg), .rsz(rsz)) u_rail_q (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .stb   (stb_q[nstg-1:0]),
    .din   (qin),
    .dout  (qrnd)
  );

  sat #(.iw(isz+1), .ow(osz)) u_sat_i (.din(irnd), .dout(isat));
  sat #(.iw(isz+1), .ow(osz)) u_sat_q (.din(qrnd), .dout(qsat));

  assign valid = valid_q;
  assign iout  = iout_q;
  assign qout  = qout_q;

endmodule

// File: tb/tb_cic_dec_iq.sv
// Self-checking bench for cic_dec_iq: impulse-response model of the whole
// decimator plus hand-computed literal expectations for each scenario.
module tb_cic_dec_iq;

   localparam int NSTG = 4;
   localparam int RSZ  = 5;
   localparam int R    = 32;
   localparam int LAT  = NSTG + 1;
   localparam int HLEN = NSTG * R;

   typedef struct {
      int     edge_n;
      longint i;
      longint q;
   } out_t;

   logic clk = 1'b0;
   logic reset;
   logic ena;
   logic signed [15:0] iin, qin;
   logic valid;
   logic signed [15:0] iout, qout;

   logic ena_w;
   logic signed [3:0] iin_w, qin_w;
   logic valid_w;
   logic signed [3:0] iout_w, qout_w;

   int checks   = 0;
   int failures = 0;

   longint h [HLEN];
   longint xi[$];
   longint xq[$];
   out_t   pend[$];
   out_t   obs[$];
   int     obs_w[$];
   int     cyc = 0;
   int     ena_cnt = 0;
   logic   exp_valid = 1'b0;
   longint exp_i = 0;
   longint exp_q = 0;

   // Clock: 10 time-unit period
   always #5 clk = ~clk;

   cic_dec_iq #(.isz(16), .osz(16), .nstg(NSTG), .rsz(RSZ)) dut (
      .clk   (clk),
      .reset (reset),
      .ena   (ena),
      .iin   (iin),
      .qin   (qin),
      .valid (valid),
      .iout  (iout),
      .qout  (qout)
   );

   // Narrow configuration whose 8-bit integrators wrap many times
   cic_dec_iq #(.isz(4), .osz(4), .nstg(2), .rsz(2)) dut_wrap (
      .clk   (clk),
      .reset (reset),
      .ena   (ena_w),
      .iin   (iin_w),
      .qin   (qin_w),
      .valid (valid_w),
      .iout  (iout_w),
      .qout  (qout_w)
   );

   task automatic checkOutput(input string name, input logic signed [63:0] act, input longint expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic applyStimulus(input logic e, input longint i, input longint q);
      @(negedge clk);
      reset = 1'b1;
      ena   = e;
      iin   = 16'(i);
      qin   = 16'(q);
      ena_w = 1'b0;
   endtask

   task automatic applyReset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         reset = 1'b0;
         ena   = (k % 2 == 0);
         iin   = 16'sd1000;
         qin   = -16'sd1000;
         ena_w = 1'b0;
      end
   endtask

   // Output of the decimator after the current sample history: the full
   // filter is N cascaded length-R boxcars delayed N-1 samples, then rounded
   // half-up by R^N and clamped to 16 bits.
   function automatic longint model_out(input bit use_q);
      longint y = 0;
      int n = use_q ? xq.size() : xi.size();
      for (int j = 0; j < HLEN; j++) begin
         int idx = n - 1 - j;
         if (idx >= 0) y += h[j] * (use_q ? xq[idx] : xi[idx]);
      end
      y = (y + (longint'(1) << (NSTG*RSZ - 1))) >>> (NSTG*RSZ);
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      return y;
   endfunction

   // Reference model: tracks samples since reset and schedules outputs LAT edges
   // after every R-th sample
   initial begin : model
      longint box [HLEN];
      longint tmp [HLEN];
      for (int k = 0; k < HLEN; k++) box[k] = 0;
      box[0] = 1;
      for (int s = 0; s < NSTG; s++) begin
         for (int k = 0; k < HLEN; k++) begin
            tmp[k] = 0;
            for (int m = 0; m < R; m++) if (k - m >= 0) tmp[k] += box[k-m];
         end
         for (int k = 0; k < HLEN; k++) box[k] = tmp[k];
      end
      for (int j = 0; j < HLEN; j++) h[j] = (j >= NSTG - 1) ? box[j-(NSTG-1)] : 0;

      forever begin
         @(posedge clk);
         cyc++;
         if (!reset) begin
            xi.delete();
            xq.delete();
            pend.delete();
            ena_cnt   = 0;
            exp_valid = 1'b0;
            exp_i     = 0;
            exp_q     = 0;
         end else begin
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].edge_n == cyc) begin
               exp_valid = 1'b1;
               exp_i     = pend[0].i;
               exp_q     = pend[0].q;
               void'(pend.pop_front());
            end
            if (ena) begin
               xi.push_back(longint'(iin));
               xq.push_back(longint'(qin));
               ena_cnt++;
               if (ena_cnt % R == 0) pend.push_back('{cyc + LAT, model_out(1'b0), model_out(1'b1)});
            end
         end
      end
   end

   // Per-cycle comparison of the main DUT against the model, plus capture of
   // every output sample for the scenario checks
   initial begin : compare
      forever begin
         @(posedge clk);
         #1;
         checkOutput("valid", valid, exp_valid);
         checkOutput("iout", iout, exp_i);
         checkOutput("qout", qout, exp_q);
         if (valid === 1'b1) obs.push_back('{cyc, longint'(iout), longint'(qout)});
         if (valid_w === 1'b1) begin
            obs_w.push_back(int'(iout_w));
            checkOutput("wrap_qout", qout_w, 0);
         end
      end
   end

   // Directed scenarios
   initial begin : stim
      int qual_edge;
      int n;
      int quals[$];
      reset = 1'b0;
      ena   = 1'b0;
      iin   = '0;
      qin   = '0;
      ena_w = 1'b0;
      iin_w = '0;
      qin_w = '0;

      // Reset with ena toggling, then DC input
      applyReset(3);
      obs.delete();
      qual_edge = 0;
      for (int k = 0; k < 6*R; k++) begin
         applyStimulus(1'b1, 1000, -1000);
         if (k == R - 1) qual_edge = cyc + 1;
      end
      repeat (8) applyStimulus(1'b0, 0, 0);
      checkOutput("dc_count", obs.size(), 6);
      if (obs.size() >= 6) begin
         checkOutput("dc_latency", obs[0].edge_n - qual_edge, LAT);
         checkOutput("dc_first_i", obs[0].i, 34);
         checkOutput("dc_first_q", obs[0].q, -34);
         for (int k = 4; k < 6; k++) begin
            checkOutput("dc_settled_i", obs[k].i, 1000);
            checkOutput("dc_settled_q", obs[k].q, -1000);
         end
      end

      // Full-scale steady input
      applyReset(1);
      obs.delete();
      for (int k = 0; k < 6*R; k++) applyStimulus(1'b1, 32767, -32768);
      repeat (8) applyStimulus(1'b0, 0, 0);
      checkOutput("fs_count", obs.size(), 6);
      if (obs.size() >= 6) begin
         for (int k = 1; k < 6; k++) begin
            checkOutput("fs_mono_i", obs[k].i >= obs[k-1].i, 1);
            checkOutput("fs_mono_q", obs[k].q <= obs[k-1].q, 1);
         end
         checkOutput("fs_settled_i", obs[5].i, 32767);
         checkOutput("fs_settled_q", obs[5].q, -32768);
      end

      // Sparse ena (every third cycle) with a ramp
      applyReset(1);
      obs.delete();
      quals.delete();
      n = 0;
      for (int k = 0; k < 3*R*4; k++) begin
         if (k % 3 == 0) begin
            n++;
            applyStimulus(1'b1, -3000 + n*53, 2000 - n*29);
            if (n % R == 0) quals.push_back(cyc + 1);
         end else begin
            applyStimulus(1'b0, 0, 0);
         end
      end
      repeat (8) applyStimulus(1'b0, 0, 0);
      checkOutput("sparse_count", obs.size(), 4);
      if (obs.size() >= 4 && quals.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            checkOutput("sparse_latency", obs[k].edge_n - quals[k], LAT);
            if (k > 0) checkOutput("sparse_gap", obs[k].edge_n - obs[k-1].edge_n, 3*R);
         end
      end

      // Reset two cycles after a qualifying ena
      applyReset(1);
      obs.delete();
      for (int k = 0; k < R; k++) applyStimulus(1'b1, 1000, -1000);
      applyStimulus(1'b1, 1000, -1000);
      applyReset(1);
      qual_edge = 0;
      for (int k = 0; k < 2*R; k++) begin
         applyStimulus(1'b1, -5000, 2500);
         if (k == R - 1) qual_edge = cyc + 1;
      end
      repeat (8) applyStimulus(1'b0, 0, 0);
      checkOutput("midrst_count", obs.size(), 2);
      if (obs.size() >= 1) begin
         checkOutput("midrst_latency", obs[0].edge_n - qual_edge, LAT);
         checkOutput("midrst_first_i", obs[0].i, -171);
         checkOutput("midrst_first_q", obs[0].q, 86);
      end

      // Narrow instance: integrators wrap, output still settles to the input
      applyReset(1);
      obs_w.delete();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         reset = 1'b1;
         ena   = 1'b0;
         ena_w = 1'b1;
         iin_w = 4'sd7;
         qin_w = 4'sd0;
      end
      repeat (8) applyStimulus(1'b0, 0, 0);
      checkOutput("wrap_count", obs_w.size(), 50);
      if (obs_w.size() >= 50) begin
         checkOutput("wrap_first", obs_w[0], 3);
         for (int k = 1; k < 50; k++) checkOutput("wrap_settled", obs_w[k], 7);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
